// File: rtl/kma_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// kma_sequencer_pkg
// Shared constants for the KMA_CPU control unit and its ALU.
//
// The `define block carries the shared "definy" constant set: the existing
// data/opcode widths and ALU opcodes, plus the program-counter width, the
// instruction width and the control opcodes (ST, JMP, JC, HLT). Control
// opcodes are placed above the ALU range so the two never collide.
// The package mirrors those macros as typed localparams for the RTL.
//
// Instruction word layout: {opcode[op_code_width-1:0], imm, arg[data_width-1:0]}
//   imm=1 : arg is the operand value
//   imm=0 : arg is a data-memory address
//
// Optional feature macro (used in kma_sequencer): KMA_SEQ_STEP_EN
// -----------------------------------------------------------------------------
`ifndef KMA_DEFINY_CONSTANTS
`define KMA_DEFINY_CONSTANTS
`define KMA_DATA_WIDTH    8
`define KMA_OP_CODE_WIDTH 4
`define KMA_PC_WIDTH      4
`define KMA_INSTR_WIDTH   13
`define NOP           4'h0
`define LD            4'h1
`define ADD           4'h2
`define SUB           4'h3
`define AND           4'h4
`define OR            4'h5
`define XOR           4'h6
`define NOT           4'h7
`define ST            4'h8
`define JMP           4'h9
`define JC            4'hA
`define HLT           4'hB
`endif

package kma_sequencer_pkg;

    localparam int DATA_WIDTH    = `KMA_DATA_WIDTH;
    localparam int OP_CODE_WIDTH = `KMA_OP_CODE_WIDTH;
    localparam int PC_WIDTH      = `KMA_PC_WIDTH;
    localparam int INSTR_WIDTH   = `KMA_INSTR_WIDTH;

    // ALU opcodes
    localparam logic [OP_CODE_WIDTH-1:0] OP_NOP = `NOP;
    localparam logic [OP_CODE_WIDTH-1:0] OP_LD  = `LD;
    localparam logic [OP_CODE_WIDTH-1:0] OP_ADD = `ADD;
    localparam logic [OP_CODE_WIDTH-1:0] OP_SUB = `SUB;
    localparam logic [OP_CODE_WIDTH-1:0] OP_AND = `AND;
    localparam logic [OP_CODE_WIDTH-1:0] OP_OR  = `OR;
    localparam logic [OP_CODE_WIDTH-1:0] OP_XOR = `XOR;
    localparam logic [OP_CODE_WIDTH-1:0] OP_NOT = `NOT;

    // Control opcodes handled entirely by the sequencer
    localparam logic [OP_CODE_WIDTH-1:0] OP_ST  = `ST;
    localparam logic [OP_CODE_WIDTH-1:0] OP_JMP = `JMP;
    localparam logic [OP_CODE_WIDTH-1:0] OP_JC  = `JC;
    localparam logic [OP_CODE_WIDTH-1:0] OP_HLT = `HLT;

endpackage

// File: rtl/kma_decode.sv
// -----------------------------------------------------------------------------
// kma_decode
// Purely combinational instruction decoder for kma_sequencer.
//
// Ports:
//   ir       in   instruction register {opcode, imm, arg}
//   op       out  opcode field (driven to the ALU as-is)
//   use_imm  out  operand select: 1 = arg is the operand, 0 = data memory
//   arg      out  argument field
//   is_alu   out  opcode is one of LD/ADD/SUB/AND/OR/XOR/NOT
//   is_st    out  store accumulator to data memory
//   is_jmp   out  unconditional jump
//   is_jc    out  jump on carry
//   is_hlt   out  halt
// Any opcode not listed decodes to all-zero flags, i.e. behaves as NOP.
// -----------------------------------------------------------------------------
module kma_decode
    import kma_sequencer_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int op_code_width = OP_CODE_WIDTH
) (
    input  logic [op_code_width+data_width:0] ir,
    output logic [op_code_width-1:0]          op,
    output logic                              use_imm,
    output logic [data_width-1:0]             arg,
    output logic                              is_alu,
    output logic                              is_st,
    output logic                              is_jmp,
    output logic                              is_jc,
    output logic                              is_hlt
);

    assign op      = ir[op_code_width+data_width -: op_code_width];
    assign use_imm = ir[data_width];
    assign arg     = ir[data_width-1:0];

    always_comb begin
        is_alu = 1'b0;
        is_st  = 1'b0;
        is_jmp = 1'b0;
        is_jc  = 1'b0;
        is_hlt = 1'b0;
        case (op)
            op_code_width'(OP_LD),
            op_code_width'(OP_ADD),
            op_code_width'(OP_SUB),
            op_code_width'(OP_AND),
            op_code_width'(OP_OR),
            op_code_width'(OP_XOR),
            op_code_width'(OP_NOT): is_alu = 1'b1;
            op_code_width'(OP_ST):  is_st  = 1'b1;
            op_code_width'(OP_JMP): is_jmp = 1'b1;
            op_code_width'(OP_JC):  is_jc  = 1'b1;
            op_code_width'(OP_HLT): is_hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/kma_sequencer.sv
// -----------------------------------------------------------------------------
// kma_sequencer
// Control unit of the KMA_CPU datapath. Fetches, decodes and executes one
// instruction every 3 clocks (FETCH -> DECODE -> EXEC), drives the ALU
// operands and latches its result/carry, performs stores, jumps and halt.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   step            (only with KMA_SEQ_STEP_EN) FETCH waits for step=1
//   pm_addr/pm_data program memory, synchronous read (1 cycle)
//   dm_addr         data memory address (early in DECODE, held in EXEC)
//   dm_rdata        data memory read data, synchronous read (1 cycle)
//   dm_wdata/dm_we  data memory write (acc, single-cycle strobe)
//   alu_op, alu_data_in, alu_cr_in   ALU opcode and operands
//   alu_data_out, alu_cy             ALU result and carry
//   acc, cy_flag, halted             architectural state observation
//
// Configuration macro: KMA_SEQ_STEP_EN (single-step control; off by default)
// -----------------------------------------------------------------------------
module kma_sequencer
    import kma_sequencer_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int op_code_width = OP_CODE_WIDTH,
    parameter int pc_width      = PC_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef KMA_SEQ_STEP_EN
    input  logic                              step,
`endif
    output logic [pc_width-1:0]               pm_addr,
    input  logic [op_code_width+data_width:0] pm_data,
    output logic [data_width-1:0]             dm_addr,
    input  logic [data_width-1:0]             dm_rdata,
    output logic [data_width-1:0]             dm_wdata,
    output logic                              dm_we,
    output logic [op_code_width-1:0]          alu_op,
    output logic [data_width-1:0]             alu_data_in,
    output logic [data_width-1:0]             alu_cr_in,
    input  logic [data_width-1:0]             alu_data_out,
    input  logic                              alu_cy,
    output logic [data_width-1:0]             acc,
    output logic                              cy_flag,
    output logic                              halted
);

    localparam int instr_width = op_code_width + 1 + data_width;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    typedef enum logic [1:0] {
        FETCH  = S_FETCH,
        DECODE = S_DECODE,
        EXEC   = S_EXEC,
        HALT   = S_HALT
    } state_t;

    state_t                  state_reg,   state_next;
    logic [pc_width-1:0]     pc_reg,      pc_next;
    logic [instr_width-1:0]  ir_reg,      ir_next;
    logic [data_width-1:0]   acc_reg,     acc_next;
    logic [data_width-1:0]   dm_addr_reg, dm_addr_next;
    logic                    cy_reg,      cy_next;

    logic [op_code_width-1:0] op;
    logic [data_width-1:0]    arg;
    logic                     use_imm;
    logic                     is_alu, is_st, is_jmp, is_jc, is_hlt;
    logic                     advance;

    kma_decode #(
        .data_width    (data_width),
        .op_code_width (op_code_width)
    ) u_decode (
        .ir      (ir_reg),
        .op      (op),
        .use_imm (use_imm),
        .arg     (arg),
        .is_alu  (is_alu),
        .is_st   (is_st),
        .is_jmp  (is_jmp),
        .is_jc   (is_jc),
        .is_hlt  (is_hlt)
    );

`ifdef KMA_SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        acc_next     = acc_reg;
        cy_next      = cy_reg;
        dm_addr_next = dm_addr_reg;
        case (state_reg)
            FETCH: begin
                if (advance) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ir_next      = pm_data;
                dm_addr_next = pm_data[data_width-1:0];
                state_next   = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc_reg + pc_width'(1);
                if (is_alu) begin
                    acc_next = alu_data_out;
                    cy_next  = alu_cy;
                end else if (is_jmp || (is_jc && cy_reg)) begin
                    pc_next = arg[pc_width-1:0];
                end else if (is_hlt) begin
                    pc_next    = pc_reg;
                    state_next = HALT;
                end
                // ST, NOP and unknown opcodes only advance pc here;
                // the store strobe is driven combinationally below.
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= '0;
            ir_reg      <= '0;
            acc_reg     <= '0;
            cy_reg      <= 1'b0;
            dm_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            acc_reg     <= acc_next;
            cy_reg      <= cy_next;
            dm_addr_reg <= dm_addr_next;
        end
    end

    // The data address is presented straight from pm_data during DECODE so
    // that a synchronous data memory returns dm_rdata in time for EXEC.
    assign dm_addr = (state_reg == DECODE) ? pm_data[data_width-1:0] : dm_addr_reg;

    // rst gates the strobe so a reset landing in EXEC of ST never writes.
    assign dm_we    = (state_reg == EXEC) && is_st && !rst;
    assign dm_wdata = acc_reg;

    assign pm_addr     = pc_reg;
    assign alu_op      = op;
    assign alu_data_in = use_imm ? arg : dm_rdata;
    assign alu_cr_in   = acc_reg;
    assign acc         = acc_reg;
    assign cy_flag     = cy_reg;
    assign halted      = (state_reg == HALT);

endmodule
